// File: rtl/top_system_if.sv
// Bus between the top_system CPU core and whatever observes it at chip level.
// The signal names match the top_system port list: addr, wdata and we.
interface top_system_if;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        we;

  modport master (output addr, output wdata, output we);
  modport slave  (input  addr, input  wdata, input  we);
endinterface

// File: rtl/top_system.sv
// top_system: 6502-subset microcomputer with a multi-cycle CPU and on-chip memory.
// Memory map: $0000-$00FF RAM, $F000-$FFFF ROM; all other addresses read $00.
// Define SHIFT_OPS_EN to add the accumulator shifts ASL/LSR/ROL/ROR (0A/4A/2A/6A).
// Without it, those four opcodes run as 2-cycle NOPs.

// On-chip memory: 4 KB ROM at the top of the address space, 256 B zero-page RAM.
// Neither array is reset; the ROM is preloaded from outside.
module top_system_mem (
  input  logic        i_clk,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_wdata,
  input  logic        i_we,
  output logic [7:0]  o_rdata
);
  logic [7:0] ROM [0:4095];
  logic [7:0] RAM [0:255];

  // combinational read decode; unmapped space reads as zero
  always_comb begin
    o_rdata = 8'h00;
    if (i_addr[15:8] == 8'h00)      o_rdata = RAM[i_addr[7:0]];
    else if (i_addr[15:12] == 4'hF) o_rdata = ROM[i_addr[11:0]];
  end

  // only zero-page writes land; ROM and unmapped writes are dropped
  always_ff @(posedge i_clk) begin
    if (i_we && (i_addr[15:8] == 8'h00)) RAM[i_addr[7:0]] <= i_wdata;
  end
endmodule

// state | meaning
// VEC0  | read $FFFC into PCL
// VEC1  | read $FFFD into PCH
// FETCH | read opcode at PC, PC++
// OP1   | operand/dummy read; 2-cycle instructions complete here
// OP2   | zero-page access, JMP high byte, or taken-branch PC update
module top_system (
  input  logic          ph1,
  input  logic          reset,
  top_system_if.master  bus
);
  typedef enum logic [2:0] {S_VEC0, S_VEC1, S_FETCH, S_OP1, S_OP2} state_t;

  state_t      r_state, w_next;
  logic [15:0] r_pc, w_pc;
  logic [7:0]  r_a, w_a, r_x, w_x, r_ir, w_ir, r_opnd, w_opnd;
  logic        r_n, w_n, r_v, w_v, r_z, w_z, r_c, w_c;
  logic [15:0] w_addr;
  logic [7:0]  w_wdata, w_rdata, w_res;
  logic        w_we, w_set_nz;
  logic [9:0]  w_alu;
  logic        w_is_imm, w_is_zp, w_is_jmp, w_is_br, w_br_taken;

  // {overflow, carry, sum}; SBC reuses this with the operand inverted
  function automatic logic [9:0] add8(input logic [7:0] a, input logic [7:0] m, input logic c);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, m} + {8'h00, c};
    return {(a[7] == m[7]) && (s[7] != a[7]), s[8], s[7:0]};
  endfunction

  assign w_is_imm   = r_ir inside {8'hA9, 8'hA2, 8'h69, 8'hE9, 8'h29, 8'h09, 8'h49};
  assign w_is_zp    = r_ir inside {8'hA5, 8'h65, 8'h85, 8'h86};
  assign w_is_jmp   = (r_ir == 8'h4C);
  assign w_is_br    = (r_ir == 8'hD0) || (r_ir == 8'hF0);
  assign w_br_taken = (r_ir == 8'hD0) ? !r_z : r_z;

  top_system_mem mem (
    .i_clk   (ph1),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .i_we    (w_we),
    .o_rdata (w_rdata)
  );

  assign bus.addr  = w_addr;
  assign bus.wdata = w_wdata;
  assign bus.we    = w_we;

  // bus address and store strobe; kept apart from next-state so read data never loops back
  always_comb begin
    w_addr  = r_pc;
    w_we    = 1'b0;
    w_wdata = 8'h00;
    case (r_state)
      S_VEC0: w_addr = 16'hFFFC;
      S_VEC1: w_addr = 16'hFFFD;
      S_OP2: begin
        if (w_is_zp) begin
          w_addr = {8'h00, r_opnd};
          if (r_ir == 8'h85) begin
            w_we    = 1'b1;
            w_wdata = r_a;
          end else if (r_ir == 8'h86) begin
            w_we    = 1'b1;
            w_wdata = r_x;
          end
        end
      end
      default: ;
    endcase
  end

  // next state and datapath updates
  always_comb begin
    w_next   = r_state;
    w_pc     = r_pc;
    w_a      = r_a;
    w_x      = r_x;
    w_n      = r_n;
    w_v      = r_v;
    w_z      = r_z;
    w_c      = r_c;
    w_ir     = r_ir;
    w_opnd   = r_opnd;
    w_alu    = 10'h000;
    w_res    = 8'h00;
    w_set_nz = 1'b0;
    case (r_state)
      S_VEC0: begin
        w_pc   = {r_pc[15:8], w_rdata};
        w_next = S_VEC1;
      end
      S_VEC1: begin
        w_pc   = {w_rdata, r_pc[7:0]};
        w_next = S_FETCH;
      end
      S_FETCH: begin
        w_ir   = w_rdata;
        w_pc   = r_pc + 16'd1;
        w_next = S_OP1;
      end
      S_OP1: begin
        w_opnd = w_rdata;
        w_next = S_FETCH;
        if (w_is_imm || w_is_zp || w_is_jmp || w_is_br) w_pc = r_pc + 16'd1;
        if (w_is_zp || w_is_jmp || (w_is_br && w_br_taken)) w_next = S_OP2;
        case (r_ir)
          8'hA9: begin w_a = w_rdata; w_res = w_rdata; w_set_nz = 1'b1; end
          8'hA2: begin w_x = w_rdata; w_res = w_rdata; w_set_nz = 1'b1; end
          8'h69, 8'hE9: begin
            w_alu    = add8(r_a, (r_ir == 8'hE9) ? ~w_rdata : w_rdata, r_c);
            w_a      = w_alu[7:0];
            w_c      = w_alu[8];
            w_v      = w_alu[9];
            w_res    = w_alu[7:0];
            w_set_nz = 1'b1;
          end
          8'h29: begin w_a = r_a & w_rdata; w_res = r_a & w_rdata; w_set_nz = 1'b1; end
          8'h09: begin w_a = r_a | w_rdata; w_res = r_a | w_rdata; w_set_nz = 1'b1; end
          8'h49: begin w_a = r_a ^ w_rdata; w_res = r_a ^ w_rdata; w_set_nz = 1'b1; end
          8'h18: w_c = 1'b0;
          8'h38: w_c = 1'b1;
          8'hE8: begin w_x = r_x + 8'd1; w_res = r_x + 8'd1; w_set_nz = 1'b1; end
          8'hCA: begin w_x = r_x - 8'd1; w_res = r_x - 8'd1; w_set_nz = 1'b1; end
          8'hAA: begin w_x = r_a; w_res = r_a; w_set_nz = 1'b1; end
          8'h8A: begin w_a = r_x; w_res = r_x; w_set_nz = 1'b1; end
`ifdef SHIFT_OPS_EN
          8'h0A: begin w_a = {r_a[6:0], 1'b0}; w_res = {r_a[6:0], 1'b0}; w_c = r_a[7]; w_set_nz = 1'b1; end
          8'h4A: begin w_a = {1'b0, r_a[7:1]}; w_res = {1'b0, r_a[7:1]}; w_c = r_a[0]; w_set_nz = 1'b1; end
          8'h2A: begin w_a = {r_a[6:0], r_c};  w_res = {r_a[6:0], r_c};  w_c = r_a[7]; w_set_nz = 1'b1; end
          8'h6A: begin w_a = {r_c, r_a[7:1]};  w_res = {r_c, r_a[7:1]};  w_c = r_a[0]; w_set_nz = 1'b1; end
`endif
          default: ;
        endcase
      end
      S_OP2: begin
        w_next = S_FETCH;
        if (w_is_jmp)     w_pc = {w_rdata, r_opnd};
        else if (w_is_br) w_pc = r_pc + {{8{r_opnd[7]}}, r_opnd};
        case (r_ir)
          8'hA5: begin w_a = w_rdata; w_res = w_rdata; w_set_nz = 1'b1; end
          8'h65: begin
            w_alu    = add8(r_a, w_rdata, r_c);
            w_a      = w_alu[7:0];
            w_c      = w_alu[8];
            w_v      = w_alu[9];
            w_res    = w_alu[7:0];
            w_set_nz = 1'b1;
          end
          default: ;
        endcase
      end
      default: w_next = S_VEC0;
    endcase
    if (w_set_nz) begin
      w_n = w_res[7];
      w_z = (w_res == 8'h00);
    end
  end

  // state and register file; reset aborts any instruction in flight
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      r_state <= S_VEC0;
      r_pc    <= 16'h0000;
      r_a     <= 8'h00;
      r_x     <= 8'h00;
      r_n     <= 1'b0;
      r_v     <= 1'b0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
      r_ir    <= 8'hEA;
      r_opnd  <= 8'h00;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc;
      r_a     <= w_a;
      r_x     <= w_x;
      r_n     <= w_n;
      r_v     <= w_v;
      r_z     <= w_z;
      r_c     <= w_c;
      r_ir    <= w_ir;
      r_opnd  <= w_opnd;
    end
  end
endmodule

// File: tb/tb_top_system.sv
// Bench for top_system: table of small programs, each with the stores it must
// produce (address, data, cycle after reset release) and the final flags.
// Expected stores go into a queue; a monitor pops them as the bus strobes we.
module tb_top_system;
  logic ph1   = 1'b0;
  logic reset = 1'b0;

  top_system_if bus_if ();
  top_system dut (.ph1(ph1), .reset(reset), .bus(bus_if));

  always #5 ph1 = ~ph1;

  typedef struct {
    string        name;
    logic [127:0] prog;
    int           len;
    int           nwr;
    logic [15:0]  a0, a1;
    logic [7:0]   d0, d1;
    int           c0, c1;
    logic [3:0]   fmask, fexp;  // {N,V,Z,C}
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
    string       name;
  } wr_t;

  vec_t vecs[$];
  wr_t  sb[$];
  wr_t  mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic void add_vec(input string nm, input logic [127:0] p, input int len, input int nwr,
                                  input logic [15:0] a0, input logic [7:0] d0, input int c0,
                                  input logic [15:0] a1, input logic [7:0] d1, input int c1,
                                  input logic [3:0] fm, input logic [3:0] fe);
    vec_t v;
    v.name = nm; v.prog = p; v.len = len; v.nwr = nwr;
    v.a0 = a0; v.d0 = d0; v.c0 = c0; v.a1 = a1; v.d1 = d1; v.c1 = c1;
    v.fmask = fm; v.fexp = fe;
    vecs.push_back(v);
  endfunction

  // cycle k after reset release is sampled on the k-th falling edge
  always @(negedge ph1) begin
    if (!reset) cyc = 0;
    else begin
      cyc = cyc + 1;
      if (bus_if.we) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0h data %0h at cycle %0d, expected no write", bus_if.addr, bus_if.wdata, cyc);
        end else begin
          mon_e = sb.pop_front();
          check({mon_e.name, "_waddr"}, 32'(bus_if.addr), 32'(mon_e.addr));
          check({mon_e.name, "_wdata"}, 32'(bus_if.wdata), 32'(mon_e.data));
          check({mon_e.name, "_wcycle"}, 32'(cyc), 32'(mon_e.cyc));
        end
      end
    end
  end

  task automatic load_rom(input logic [127:0] p, input int len);
    for (int i = 0; i < 4096; i++) dut.mem.ROM[12'(i)] = 8'hEA;
    for (int i = 0; i < len; i++) dut.mem.ROM[12'(i)] = p[8*(len-1-i) +: 8];
    dut.mem.ROM[12'(len)]   = 8'h4C;
    dut.mem.ROM[12'(len+1)] = 8'(len);
    dut.mem.ROM[12'(len+2)] = 8'hF0;
    dut.mem.ROM[12'hFFC] = 8'h00;
    dut.mem.ROM[12'hFFD] = 8'hF0;
  endtask

  task automatic enter_reset(input string nm);
    @(posedge ph1);
    #1 reset = 1'b0;
    #1;
    check({nm, "_rst_addr"}, 32'(bus_if.addr), 32'h0000FFFC);
    check({nm, "_rst_we"}, 32'(bus_if.we), 32'h0);
    check({nm, "_rst_wdata"}, 32'(bus_if.wdata), 32'h0);
  endtask

  task automatic release_and_drain(input string nm);
    int t;
    repeat (5) @(posedge ph1);
    #1 reset = 1'b1;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge ph1);
      t++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: %0d stores still pending, expected 0", nm, sb.size());
      sb.delete();
    end
    repeat (10) @(posedge ph1);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    wr_t w;
    enter_reset(v.name);
    load_rom(v.prog, v.len);
    sb.delete();
    w.name = v.name; w.addr = v.a0; w.data = v.d0; w.cyc = v.c0;
    sb.push_back(w);
    if (v.nwr > 1) begin
      w.addr = v.a1; w.data = v.d1; w.cyc = v.c1;
      sb.push_back(w);
    end
    release_and_drain(v.name);
    check({v.name, "_flags"}, 32'({dut.r_n, dut.r_v, dut.r_z, dut.r_c} & v.fmask), 32'(v.fexp & v.fmask));
    check({v.name, "_ram0"}, 32'(dut.mem.RAM[v.a0[7:0]]), 32'(v.d0));
    if (v.nwr > 1) check({v.name, "_ram1"}, 32'(dut.mem.RAM[v.a1[7:0]]), 32'(v.d1));
  endtask

  initial begin
    wr_t w;
    add_vec("power",    80'hA9_67_18_69_68_85_42_4C_07_F0, 10, 1, 16'h0042, 8'hCF, 11, 16'h0, 8'h0, 0, 4'hF, 4'b1100);
    add_vec("flags",    48'hA9_FF_69_01_85_10,              6, 1, 16'h0010, 8'h00,  9, 16'h0, 8'h0, 0, 4'hF, 4'b0011);
    add_vec("loop",     56'hA2_03_CA_D0_FD_86_20,           7, 1, 16'h0020, 8'h00, 21, 16'h0, 8'h0, 0, 4'hF, 4'b0010);
    add_vec("subtract", 56'h38_A9_50_E9_F0_85_30,           7, 1, 16'h0030, 8'h60, 11, 16'h0, 8'h0, 0, 4'hF, 4'b0000);
    add_vec("borrow",   56'h38_A9_10_E9_20_85_66,           7, 1, 16'h0066, 8'hF0, 11, 16'h0, 8'h0, 0, 4'hF, 4'b1000);
    add_vec("logic",    80'hA9_F0_29_3C_09_01_49_FF_85_50, 10, 1, 16'h0050, 8'hCE, 13, 16'h0, 8'h0, 0, 4'hF, 4'b1000);
    add_vec("xfer",     56'hA9_7F_AA_E8_8A_85_51,           7, 1, 16'h0051, 8'h80, 13, 16'h0, 8'h0, 0, 4'hF, 4'b1000);
    add_vec("dexwrap",  40'hA2_00_CA_86_52,                 5, 1, 16'h0052, 8'hFF,  9, 16'h0, 8'h0, 0, 4'hF, 4'b1000);
    add_vec("zpage",    80'hA9_05_85_60_A5_60_65_60_85_61, 10, 2, 16'h0060, 8'h05,  7, 16'h0061, 8'h0A, 16, 4'hF, 4'b0000);
    add_vec("jmpbeq",   96'hA9_00_F0_02_A9_11_4C_0A_F0_EA_85_62, 12, 1, 16'h0062, 8'h00, 13, 16'h0, 8'h0, 0, 4'hF, 4'b0010);
    add_vec("ovf",      48'hA9_50_69_50_85_63,              6, 1, 16'h0063, 8'hA0,  9, 16'h0, 8'h0, 0, 4'hF, 4'b1100);
    add_vec("undef",    40'hA9_33_02_85_64,                 5, 1, 16'h0064, 8'h33,  9, 16'h0, 8'h0, 0, 4'hF, 4'b0000);
`ifdef SHIFT_OPS_EN
    add_vec("asl",      40'hA9_81_0A_85_40,                 5, 1, 16'h0040, 8'h02,  9, 16'h0, 8'h0, 0, 4'hF, 4'b0001);
    add_vec("ror",      48'hA9_01_38_6A_85_65,              6, 1, 16'h0065, 8'h80, 11, 16'h0, 8'h0, 0, 4'hF, 4'b1001);
`else
    add_vec("asl",      40'hA9_81_0A_85_40,                 5, 1, 16'h0040, 8'h81,  9, 16'h0, 8'h0, 0, 4'hF, 4'b1000);
    add_vec("ror",      48'hA9_01_38_6A_85_65,              6, 1, 16'h0065, 8'h01, 11, 16'h0, 8'h0, 0, 4'hF, 4'b0001);
`endif
    add_vec("preabort", 32'hA9_55_85_70,                    4, 1, 16'h0070, 8'h55,  7, 16'h0, 8'h0, 0, 4'hF, 4'b0000);

    for (int k = 0; k < vecs.size(); k++) run_vec(vecs[k]);

    // Reset falling during the store cycle must drop the write and restart from the vector
    enter_reset("abort");
    load_rom(32'hA9_AA_85_70, 4);
    sb.delete();
    repeat (5) @(posedge ph1);
    #1 reset = 1'b1;
    repeat (6) @(posedge ph1);
    #1;
    check("abort_we_before", 32'(bus_if.we), 32'h1);
    check("abort_addr_before", 32'(bus_if.addr), 32'h00000070);
    reset = 1'b0;
    #1;
    check("abort_addr_now", 32'(bus_if.addr), 32'h0000FFFC);
    check("abort_we_now", 32'(bus_if.we), 32'h0);
    repeat (3) @(posedge ph1);
    #1;
    check("abort_ram_kept", 32'(dut.mem.RAM[8'h70]), 32'h55);
    w.name = "restart"; w.addr = 16'h0070; w.data = 8'hAA; w.cyc = 7;
    sb.push_back(w);
    release_and_drain("restart");
    check("restart_ram", 32'(dut.mem.RAM[8'h70]), 32'hAA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
